// File: rtl/bcd_frame_sequencer.sv
// -----------------------------------------------------------------------------
// bcd_frame_sequencer
//
// Upstream feeder for the SPI byte writer of the decimal-counter design.
// Keeps a DIGITS-wide BCD up-counter and, whenever the count changes (tick or
// clear), sends one frame to the writer: HEADER followed by one byte per digit,
// most significant digit first. Each digit byte carries the digit index in the
// high nibble and the digit value in the low nibble. A frame is a snapshot of
// the count taken in the cycle the frame starts. Changes that land while a
// frame is in flight collapse into a single follow-up frame.
//
// Handshake with the writer:
//   The writer raises RDY_write while it can take a byte. EN_write is a
//   one-cycle strobe that is only ever asserted in a cycle where RDY_write is
//   high. write_data is valid with EN_write and keeps its last value otherwise.
//   The writer drops RDY_write the cycle after a strobe, so the sequencer
//   spends one GAP cycle ignoring RDY_write after every strobe.
//
// Ports:
//   CLK          in   1          clock, rising edge
//   RST_N        in   1          asynchronous active-low reset
//   EN_tick      in   1          count-increment request, 1-cycle pulse
//   EN_clear     in   1          synchronous clear of the counter to 0
//   RDY_write    in   1          writer idle and able to accept a byte
//   EN_write     out  1          writer byte strobe, 1 cycle
//   write_data   out  8          byte presented with EN_write
//   count_value  out  DIGITS*4   live BCD count, digit 0 in bits [3:0]
//   carry        out  1          1-cycle pulse on wrap from all-9s to 0
//   busy         out  1          frame in progress (state != IDLE)
// -----------------------------------------------------------------------------
module bcd_frame_sequencer #(
    parameter int         DIGITS = 4,
    parameter logic [7:0] HEADER = 8'hAA
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  EN_tick,
    input  logic                  EN_clear,
    input  logic                  RDY_write,
    output logic                  EN_write,
    output logic [7:0]            write_data,
    output logic [DIGITS*4-1:0]   count_value,
    output logic                  carry,
    output logic                  busy
);

    localparam int CW    = DIGITS * 4;
    localparam int IDX_W = $clog2(DIGITS + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e           state_q,   state_d;
    logic [IDX_W-1:0] idx_q,     idx_d;
    logic [CW-1:0]    count_q,   count_d;
    logic [CW-1:0]    snap_q,    snap_d;
    logic             pending_q, pending_d;
    logic             carry_q,   carry_d;
    logic [7:0]       data_q,    data_d;

    // Combinational helpers
    logic [CW-1:0]    inc_value;
    logic             inc_wrap;
    logic             frame_start;
    logic             strobe;
    logic [7:0]       cur_byte;

    // -------------------------------------------------------------------------
    // BCD increment: ripple a carry up from digit 0. A digit at 9 rolls to 0
    // and passes the carry on; the first digit below 9 absorbs it. If the
    // carry survives past the top digit the counter wrapped from all-9s.
    // -------------------------------------------------------------------------
    always_comb begin : p_bcd_inc
        logic ripple;
        inc_value = count_q;
        ripple    = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if (ripple) begin
                if (count_q[d*4 +: 4] == 4'd9) begin
                    inc_value[d*4 +: 4] = 4'd0;
                end else begin
                    inc_value[d*4 +: 4] = count_q[d*4 +: 4] + 4'd1;
                    ripple              = 1'b0;
                end
            end
        end
        inc_wrap = ripple;
    end

    // -------------------------------------------------------------------------
    // Counter, carry and pending flag. The counter never stalls for a frame.
    // Clear wins over a simultaneous tick. A tick or clear in the same cycle
    // that a frame starts re-arms pending, so the new value gets its own frame.
    // -------------------------------------------------------------------------
    always_comb begin
        count_d   = count_q;
        carry_d   = 1'b0;
        pending_d = pending_q;

        if (EN_clear) begin
            count_d = '0;
        end else if (EN_tick) begin
            count_d = inc_value;
            carry_d = inc_wrap;
        end

        if (EN_tick || EN_clear) begin
            pending_d = 1'b1;
        end else if (frame_start) begin
            pending_d = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Byte selection. idx 0 is the header; idx k selects digit DIGITS-k of the
    // snapshot, so the most significant digit goes out first.
    // -------------------------------------------------------------------------
    always_comb begin : p_byte_sel
        logic [4:0] pos;
        logic [3:0] digit;
        pos   = 5'(DIGITS) - 5'(idx_q);
        digit = 4'd0;
        for (int d = 0; d < DIGITS; d++) begin
            if (pos == 5'(d)) begin
                digit = snap_q[d*4 +: 4];
            end
        end
        if (idx_q == '0) begin
            cur_byte = HEADER;
        end else begin
            cur_byte = {pos[3:0], digit};
        end
    end

    // -------------------------------------------------------------------------
    // Frame FSM: next state and strobe
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        snap_d      = snap_q;
        data_d      = data_q;
        frame_start = 1'b0;
        strobe      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pending_q) begin
                    frame_start = 1'b1;
                    snap_d      = count_q;
                    idx_d       = '0;
                    state_d     = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                // The strobe is combinational on RDY_write so a byte goes out
                // in the very cycle the writer becomes ready.
                if (RDY_write) begin
                    strobe  = 1'b1;
                    data_d  = cur_byte;
                    state_d = ST_GAP;
                end
            end

            ST_GAP: begin
                if (idx_q == IDX_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = ST_ISSUE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            count_q   <= '0;
            snap_q    <= '0;
            pending_q <= 1'b0;
            carry_q   <= 1'b0;
            data_q    <= 8'h00;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            count_q   <= count_d;
            snap_q    <= snap_d;
            pending_q <= pending_d;
            carry_q   <= carry_d;
            data_q    <= data_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs. EN_write derives from the state register, so an asynchronous
    // reset drops it immediately. write_data shows the live byte during the
    // strobe and the last sent byte otherwise.
    // -------------------------------------------------------------------------
    assign EN_write    = strobe;
    assign write_data  = strobe ? cur_byte : data_q;
    assign count_value = count_q;
    assign carry       = carry_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bcd_frame_sequencer.sv
module tb_bcd_frame_sequencer;

  localparam int DIGITS = 4;

  // clock / reset block
  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        EN_tick = 1'b0;
  logic        EN_clear = 1'b0;
  logic        RDY_write = 1'b1;
  logic        EN_write;
  logic [7:0]  write_data;
  logic [15:0] count_value;
  logic        carry;
  logic        busy;

  always #5 CLK = ~CLK;

  bcd_frame_sequencer #(.DIGITS(DIGITS), .HEADER(8'hAA)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .EN_tick     (EN_tick),
    .EN_clear    (EN_clear),
    .RDY_write   (RDY_write),
    .EN_write    (EN_write),
    .write_data  (write_data),
    .count_value (count_value),
    .carry       (carry),
    .busy        (busy)
  );

  int checks = 0;
  int errors = 0;

  // scoreboard
  logic [7:0] cap_q[$];
  logic [7:0] exp_q[$];

  int hold = 0;
  bit rdy_block = 1'b0;
  int cyc = 0;
  int last_strobe = -100;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // writer model: captures strobes, holds RDY_write low for 20 cycles after each
  always @(negedge CLK) begin
    cyc++;
    if (EN_write === 1'b1) begin
      check("strobe_while_rdy", {31'd0, RDY_write}, 32'd1);
      check("strobe_spacing", (cyc - last_strobe >= 2) ? 32'd1 : 32'd0, 32'd1);
      last_strobe = cyc;
      cap_q.push_back(write_data);
      hold = 20;
    end else if (hold > 0) begin
      hold--;
    end
  end

  always @(posedge CLK) begin
    #1;
    RDY_write = (hold == 0) && !rdy_block;
  end

  // driver tasks
  task automatic pulse_ticks(input int n);
    @(posedge CLK); #1;
    EN_tick = 1'b1;
    repeat (n) @(posedge CLK);
    #1;
    EN_tick = 1'b0;
  endtask

  task automatic wait_bytes(input string tag, input int n);
    bit got = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK); #1;
      if (cap_q.size() >= n) begin
        got = 1'b1;
        break;
      end
    end
    check(tag, {31'd0, got}, 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int run = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge CLK); #1;
      if (!busy) run++;
      else run = 0;
      if (run >= 4) break;
    end
    check(tag, (run >= 4) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic compare_bytes(input string tag);
    check($sformatf("%s_len", tag), cap_q.size(), exp_q.size());
    for (int i = 0; exp_q.size() > 0 && cap_q.size() > 0; i++) begin
      logic [7:0] a;
      logic [7:0] e;
      a = cap_q.pop_front();
      e = exp_q.pop_front();
      check($sformatf("%s_b%0d", tag, i), {24'd0, a}, {24'd0, e});
    end
    cap_q.delete();
    exp_q.delete();
  endtask

  initial begin
    // ---- Test 1: reset state, one tick, latency, frame, busy fall ----
    repeat (3) @(negedge CLK);
    #1;
    check("rst_count", {16'd0, count_value}, 32'h0);
    check("rst_en_write", {31'd0, EN_write}, 32'd0);
    check("rst_write_data", {24'd0, write_data}, 32'h0);
    check("rst_carry", {31'd0, carry}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (10) @(negedge CLK);
    #1;
    check("no_frame_after_rst", cap_q.size(), 32'd0);
    check("idle_after_rst", {31'd0, busy}, 32'd0);

    pulse_ticks(1);
    @(negedge CLK); #1;
    check("t1_count", {16'd0, count_value}, 32'h0001);
    check("t1_no_strobe_yet", {31'd0, EN_write}, 32'd0);
    @(negedge CLK); #1;
    check("t1_latency_strobe", {31'd0, EN_write}, 32'd1);
    check("t1_first_byte", {24'd0, write_data}, 32'hAA);
    check("t1_busy", {31'd0, busy}, 32'd1);
    wait_bytes("t1_bytes_arrive", 5);
    check("t1_hold_data", {24'd0, write_data}, 32'h01);
    @(negedge CLK); #1;
    check("t1_busy_in_gap", {31'd0, busy}, 32'd1);
    check("t1_data_held", {24'd0, write_data}, 32'h01);
    @(negedge CLK); #1;
    check("t1_busy_fall", {31'd0, busy}, 32'd0);
    exp_q = {8'hAA, 8'h30, 8'h20, 8'h10, 8'h01};
    compare_bytes("t1_frame");

    // ---- Test 2: preload 9999, wrap with carry ----
    pulse_ticks(9998);
    wait_idle("t2_preload_idle");
    cap_q.delete();
    check("t2_preload", {16'd0, count_value}, 32'h9999);
    pulse_ticks(1);
    @(negedge CLK); #1;
    check("t2_wrap_count", {16'd0, count_value}, 32'h0000);
    check("t2_carry_high", {31'd0, carry}, 32'd1);
    @(negedge CLK); #1;
    check("t2_carry_low", {31'd0, carry}, 32'd0);
    wait_idle("t2_idle");
    exp_q = {8'hAA, 8'h30, 8'h20, 8'h10, 8'h00};
    compare_bytes("t2_frame");

    // ---- Test 3: ticks during a frame coalesce into one extra frame ----
    pulse_ticks(1);
    wait_bytes("t3_first_byte", 1);
    pulse_ticks(1);
    repeat (5) @(negedge CLK);
    pulse_ticks(3);
    @(negedge CLK); #1;
    check("t3_count", {16'd0, count_value}, 32'h0005);
    wait_idle("t3_idle");
    exp_q = {8'hAA, 8'h30, 8'h20, 8'h10, 8'h01,
             8'hAA, 8'h30, 8'h20, 8'h10, 8'h05};
    compare_bytes("t3_frames");

    // ---- Test 4: tick and clear together at 0042 ----
    pulse_ticks(37);
    wait_idle("t4_preload_idle");
    cap_q.delete();
    check("t4_preload", {16'd0, count_value}, 32'h0042);
    @(posedge CLK); #1;
    EN_tick = 1'b1;
    EN_clear = 1'b1;
    @(posedge CLK); #1;
    EN_tick = 1'b0;
    EN_clear = 1'b0;
    @(negedge CLK); #1;
    check("t4_clear_wins", {16'd0, count_value}, 32'h0000);
    check("t4_no_carry", {31'd0, carry}, 32'd0);
    wait_idle("t4_idle");
    exp_q = {8'hAA, 8'h30, 8'h20, 8'h10, 8'h00};
    compare_bytes("t4_frame");

    // ---- Test 5: RDY_write held low for 50 cycles while pending ----
    @(negedge CLK);
    rdy_block = 1'b1;
    @(negedge CLK);
    pulse_ticks(1);
    begin
      int seen = 0;
      for (int i = 0; i < 50; i++) begin
        @(negedge CLK); #1;
        if (EN_write !== 1'b0) seen++;
      end
      check("t5_no_strobe", seen, 32'd0);
    end
    check("t5_busy_waiting", {31'd0, busy}, 32'd1);
    check("t5_no_bytes", cap_q.size(), 32'd0);
    @(negedge CLK);
    rdy_block = 1'b0;
    @(posedge CLK); #2;
    check("t5_rdy_up", {31'd0, RDY_write}, 32'd1);
    check("t5_same_cycle_strobe", {31'd0, EN_write}, 32'd1);
    check("t5_same_cycle_data", {24'd0, write_data}, 32'hAA);
    wait_idle("t5_idle");
    exp_q = {8'hAA, 8'h30, 8'h20, 8'h10, 8'h01};
    compare_bytes("t5_frame");

    // ---- Test 6: reset mid-frame ----
    pulse_ticks(1);
    wait_bytes("t6_two_bytes", 2);
    begin
      bit got = 1'b0;
      for (int i = 0; i < 100; i++) begin
        @(posedge CLK); #2;
        if (EN_write === 1'b1) begin
          got = 1'b1;
          break;
        end
      end
      check("t6_third_strobe", {31'd0, got}, 32'd1);
    end
    check("t6_third_byte", {24'd0, write_data}, 32'h20);
    RST_N = 1'b0;
    #1;
    check("t6_en_write_low", {31'd0, EN_write}, 32'd0);
    check("t6_busy_low", {31'd0, busy}, 32'd0);
    check("t6_count_zero", {16'd0, count_value}, 32'h0000);
    check("t6_data_zero", {24'd0, write_data}, 32'h00);
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    repeat (60) @(negedge CLK);
    #1;
    check("t6_quiet_busy", {31'd0, busy}, 32'd0);
    exp_q = {8'hAA, 8'h30};
    compare_bytes("t6_partial");
    pulse_ticks(1);
    wait_idle("t6_idle");
    exp_q = {8'hAA, 8'h30, 8'h20, 8'h10, 8'h01};
    compare_bytes("t6_after_rst");

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
